// File: rtl/matrix_keypad_scanner_if.sv
// Key-event stream from matrix_keypad_scanner toward its consumer.
// master drives the code/valid/overflow, slave returns ready.
interface matrix_keypad_scanner_if #(
    parameter int unsigned CODE_W = 5
);
    logic [CODE_W-1:0] o_data;
    logic              o_valid;
    logic              i_ready;
    logic              o_overflow;

    modport master (output o_data, output o_valid, output o_overflow, input i_ready);
    modport slave  (input o_data, input o_valid, input o_overflow, output i_ready);
endinterface

// File: rtl/matrix_keypad_scanner.sv
// matrix_keypad_scanner: scans an R x C key matrix plus discrete function pins, debounces
// whole frame results, rejects multi-key rollover and queues key codes in a small FIFO.
// Optional feature: define KEYPAD_AUTOREPEAT_EN to re-push a held key after REPEAT_DELAY
// frames and then every REPEAT_PERIOD frames.
module matrix_keypad_scanner #(
    parameter int unsigned NUM_ROWS        = 4,
    parameter int unsigned NUM_COLS        = 4,
    parameter int unsigned NUM_FUNC        = 6,
    parameter int unsigned SETTLE_CYCLES   = 3,
    parameter int unsigned DEBOUNCE_FRAMES = 4,
    parameter int unsigned FIFO_DEPTH      = 4
`ifdef KEYPAD_AUTOREPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY    = 32,
    parameter int unsigned REPEAT_PERIOD   = 8
`endif
) (
    input  logic                           clk,
    input  logic                           rst_n,
    output logic [NUM_ROWS-1:0]            o_word_lines,
    input  logic [NUM_COLS-1:0]            i_bit_lines,
    input  logic [NUM_FUNC-1:0]            i_func_pins,
    matrix_keypad_scanner_if.master        io_evt
);
    localparam int unsigned CODE_W = $clog2(NUM_ROWS * NUM_COLS + NUM_FUNC);
    localparam int unsigned ROW_W  = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int unsigned SET_W  = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned DB_W   = $clog2(DEBOUNCE_FRAMES + 1);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

    typedef enum logic [1:0] {KindNone, KindKey, KindMulti} kind_e;

    logic [NUM_COLS-1:0] r_col_s1, r_col_s2;
    logic [NUM_FUNC-1:0] r_fn_s1, r_fn_s2;
    logic                r_run;
    logic [ROW_W-1:0]    r_row;
    logic [SET_W-1:0]    r_settle;
    logic [1:0]          r_acc_hits;
    logic [CODE_W-1:0]   r_acc_code;
    kind_e               r_last_kind, r_stable_kind, w_kind;
    logic [CODE_W-1:0]   r_last_code, r_stable_code;
    logic [DB_W-1:0]     r_match, w_match_nxt;
    logic                w_sample, w_frame_end;
    logic [1:0]          w_hits;
    logic [CODE_W-1:0]   w_code, w_res_code, w_push_code;
    logic                w_same_last, w_accept, w_push_evt, w_push, w_rep_push;

    logic [CODE_W-1:0]   r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr, r_rd_ptr, w_rd_nxt;
    logic [CNT_W-1:0]    r_count;
    logic [CODE_W-1:0]   r_data, w_data_nxt;
    logic                r_ovf, w_full, w_pop, w_wr, w_drop;

    // Two-flop synchronisers for the asynchronous sense inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col_s1 <= '0;
            r_col_s2 <= '0;
            r_fn_s1  <= '0;
            r_fn_s2  <= '0;
        end else begin
            r_col_s1 <= i_bit_lines;
            r_col_s2 <= r_col_s1;
            r_fn_s1  <= i_func_pins;
            r_fn_s2  <= r_fn_s1;
        end
    end

    // Row scanner: each row held SETTLE_CYCLES+1 cycles, sampled on the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run    <= 1'b0;
            r_row    <= '0;
            r_settle <= '0;
        end else begin
            r_run <= 1'b1;
            if (w_sample) begin
                r_settle <= '0;
                r_row    <= (r_row == ROW_W'(NUM_ROWS - 1)) ? '0 : r_row + 1'b1;
            end else if (r_run) begin
                r_settle <= r_settle + 1'b1;
            end
        end
    end

    // Row drive and frame-result accumulation (hit count saturates at 2 = multi).
    always_comb begin
        o_word_lines = '0;
        if (r_run) o_word_lines[r_row] = 1'b1;
        w_sample    = r_run && (r_settle == SET_W'(SETTLE_CYCLES));
        w_frame_end = w_sample && (r_row == ROW_W'(NUM_ROWS - 1));
        w_hits      = r_acc_hits;
        w_code      = r_acc_code;
        for (int c = 0; c < NUM_COLS; c++) begin
            if (r_col_s2[c]) begin
                w_hits = (w_hits == 2'd0) ? 2'd1 : 2'd2;
                w_code = CODE_W'(int'(r_row) * int'(NUM_COLS) + c);
            end
        end
        if (w_frame_end) begin
            for (int f = 0; f < NUM_FUNC; f++) begin
                if (r_fn_s2[f]) begin
                    w_hits = (w_hits == 2'd0) ? 2'd1 : 2'd2;
                    w_code = CODE_W'(int'(NUM_ROWS * NUM_COLS) + f);
                end
            end
        end
        // Code is only meaningful for a single key; zero it so results compare cleanly.
        w_kind     = (w_hits == 2'd0) ? KindNone : (w_hits == 2'd1) ? KindKey : KindMulti;
        w_res_code = (w_kind == KindKey) ? w_code : '0;
    end

    // Partial frame accumulator, cleared at each frame end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_hits <= '0;
            r_acc_code <= '0;
        end else if (w_frame_end) begin
            r_acc_hits <= '0;
            r_acc_code <= '0;
        end else if (w_sample) begin
            r_acc_hits <= w_hits;
            r_acc_code <= w_code;
        end
    end

    // Debounce decision; only NONE/KEY -> KEY k transitions produce an event.
    always_comb begin
        w_same_last = (w_kind == r_last_kind) && (w_res_code == r_last_code);
        if (!w_same_last) begin
            w_match_nxt = DB_W'(1);
        end else if (r_match == DB_W'(DEBOUNCE_FRAMES)) begin
            w_match_nxt = r_match;
        end else begin
            w_match_nxt = r_match + 1'b1;
        end
        w_accept    = w_frame_end && (w_match_nxt == DB_W'(DEBOUNCE_FRAMES)) &&
                      !((w_kind == r_stable_kind) && (w_res_code == r_stable_code));
        w_push_evt  = w_accept && (w_kind == KindKey) && (r_stable_kind != KindMulti);
        w_push      = w_push_evt || w_rep_push;
        w_push_code = w_push_evt ? w_res_code : r_stable_code;
    end

    // Debounce state: last frame result, match run length and accepted (stable) result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_kind   <= KindNone;
            r_last_code   <= '0;
            r_match       <= '0;
            r_stable_kind <= KindNone;
            r_stable_code <= '0;
        end else if (w_frame_end) begin
            r_last_kind <= w_kind;
            r_last_code <= w_res_code;
            r_match     <= w_match_nxt;
            if (w_accept) begin
                r_stable_kind <= w_kind;
                r_stable_code <= w_res_code;
            end
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    logic [15:0] r_rep_cnt;
    logic        r_rep_phase;
    logic [15:0] w_rep_thr;

    // Repeat timer: phase 0 waits REPEAT_DELAY frames, phase 1 REPEAT_PERIOD frames.
    always_comb begin
        w_rep_thr  = r_rep_phase ? 16'(REPEAT_PERIOD) : 16'(REPEAT_DELAY);
        w_rep_push = w_frame_end && !w_accept && (r_stable_kind == KindKey) &&
                     (r_rep_cnt + 16'd1 == w_rep_thr);
    end

    // Repeat counter restarts on any stable change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rep_cnt   <= '0;
            r_rep_phase <= 1'b0;
        end else if (w_frame_end) begin
            if (w_accept || (r_stable_kind != KindKey)) begin
                r_rep_cnt   <= '0;
                r_rep_phase <= 1'b0;
            end else if (w_rep_push) begin
                r_rep_cnt   <= '0;
                r_rep_phase <= 1'b1;
            end else begin
                r_rep_cnt <= r_rep_cnt + 16'd1;
            end
        end
    end
`else
    assign w_rep_push = 1'b0;
`endif

    // FIFO control and next head value; a pop frees a full slot for a same-cycle push.
    always_comb begin
        w_full     = (r_count == CNT_W'(FIFO_DEPTH));
        w_pop      = (r_count != '0) && io_evt.i_ready;
        w_wr       = w_push && (!w_full || w_pop);
        w_drop     = w_push && w_full && !w_pop;
        w_rd_nxt   = r_rd_ptr + 1'b1;
        w_data_nxt = r_data;
        if (w_pop) begin
            if (r_count > CNT_W'(1)) begin
                w_data_nxt = r_mem[w_rd_nxt];
            end else if (w_wr) begin
                w_data_nxt = w_push_code;
            end
        end else if ((r_count == '0) && w_wr) begin
            w_data_nxt = w_push_code;
        end
    end

    // FIFO storage (no reset needed; occupancy gates every read).
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= w_push_code;
    end

    // FIFO pointers, occupancy, registered head and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_data   <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= w_rd_nxt;
            r_count <= r_count + CNT_W'(w_wr) - CNT_W'(w_pop);
            r_data  <= w_data_nxt;
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (w_pop) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign io_evt.o_data     = r_data;
    assign io_evt.o_valid    = (r_count != '0);
    assign io_evt.o_overflow = r_ovf;

endmodule

// File: tb/tb_matrix_keypad_scanner.sv
// Bench for matrix_keypad_scanner: matrix modelled from the word lines, expected key codes
// queued as stimulus is driven and compared when the consumer side accepts a transfer.
module tb_matrix_keypad_scanner;
    localparam int unsigned NR    = 4;
    localparam int unsigned NC    = 4;
    localparam int unsigned NF    = 6;
    localparam int unsigned CW    = 5;
    localparam int unsigned FRAME = 16;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NR-1:0]         word_lines;
    logic [NC-1:0]         bit_lines;
    logic [NF-1:0]         func_pins = '0;
    logic [NR-1:0][NC-1:0] pressed = '0;

    int                    checks = 0;
    int                    errors = 0;
    int                    n_xfer = 0;
    longint unsigned       cyc = 0;
    logic [CW-1:0]         exp_q[$];
    longint unsigned       xfer_cyc[$];

    matrix_keypad_scanner_if #(.CODE_W(CW)) evt_if ();

    matrix_keypad_scanner dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .o_word_lines (word_lines),
        .i_bit_lines  (bit_lines),
        .i_func_pins  (func_pins),
        .io_evt       (evt_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Key matrix: a column reads high when a pressed key sits on the driven row.
    always_comb begin
        bit_lines = '0;
        for (int r = 0; r < NR; r++) begin
            for (int c = 0; c < NC; c++) begin
                if (pressed[r][c] && word_lines[r]) bit_lines[c] = 1'b1;
            end
        end
    end

    // Scoreboard: every accepted transfer must match the oldest expected code.
    always @(negedge clk) begin
        logic [CW-1:0] exp_v;
        if (rst_n && evt_if.o_valid && evt_if.i_ready) begin
            n_xfer++;
            xfer_cyc.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL xfer_unexpected: got o_data=%0d, expected no transfer",
                         evt_if.o_data);
            end else begin
                exp_v = exp_q.pop_front();
                if (evt_if.o_data !== exp_v) begin
                    errors++;
                    $display("FAIL xfer_data: got o_data=%0d, expected %0d", evt_if.o_data, exp_v);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        evt_if.i_ready = 1'b0;
        step(3);
        checks++;
        if (word_lines !== '0) begin
            errors++; $display("FAIL reset_word_lines: got %b, expected 0000", word_lines);
        end
        checks++;
        if (evt_if.o_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b, expected 0", evt_if.o_valid);
        end
        checks++;
        if (evt_if.o_data !== '0) begin
            errors++; $display("FAIL reset_data: got %0d, expected 0", evt_if.o_data);
        end
        checks++;
        if (evt_if.o_overflow !== 1'b0) begin
            errors++; $display("FAIL reset_overflow: got %b, expected 0", evt_if.o_overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (word_lines !== '0) begin
            errors++; $display("FAIL release_before_edge: got %b, expected 0000", word_lines);
        end
        step(1);
        checks++;
        if (word_lines !== 4'b0001) begin
            errors++; $display("FAIL release_row0: got %b, expected 0001", word_lines);
        end
    endtask

    task automatic test_single_press();
        int  x0;
        int  lat;
        bit  seen;
        evt_if.i_ready = 1'b1;
        x0 = n_xfer;
        seen = 1'b0;
        lat = 0;
        exp_q.push_back(5'd6);
        pressed[1][2] = 1'b1;
        for (int i = 1; i <= int'(8 * FRAME); i++) begin
            @(negedge clk);
            if (!seen && evt_if.o_valid) begin
                seen = 1'b1;
                lat = i;
            end
        end
        step(1);
        pressed[1][2] = 1'b0;
        step(8 * FRAME);
        checks++;
        if (!seen || lat > 82) begin
            errors++;
            $display("FAIL press_latency: got seen=%0d after %0d cycles, expected within 82",
                     seen, lat);
        end
        checks++;
        if (n_xfer - x0 != 1) begin
            errors++; $display("FAIL press_count: got %0d transfers, expected 1", n_xfer - x0);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL press_pending: got %0d missing, expected 0", exp_q.size());
        end
    endtask

    task automatic test_bounce();
        int x0;
        x0 = n_xfer;
        exp_q.push_back(5'd6);
        pressed[1][2] = 1'b1; step(20);
        pressed[1][2] = 1'b0; step(20);
        pressed[1][2] = 1'b1; step(20);
        step(8 * FRAME);
        pressed[1][2] = 1'b0;
        step(8 * FRAME);
        checks++;
        if (n_xfer - x0 != 1) begin
            errors++; $display("FAIL bounce_count: got %0d transfers, expected 1", n_xfer - x0);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL bounce_pending: got %0d missing, expected 0", exp_q.size());
        end
    endtask

    task automatic test_rollover();
        int x0;
        x0 = n_xfer;
        pressed[0][0] = 1'b1;
        pressed[2][3] = 1'b1;
        step(8 * FRAME);
        pressed[2][3] = 1'b0;
        step(8 * FRAME);
        checks++;
        if (n_xfer - x0 != 0) begin
            errors++;
            $display("FAIL rollover_multi_to_key: got %0d transfers, expected 0", n_xfer - x0);
        end
        pressed[0][0] = 1'b0;
        step(8 * FRAME);
        exp_q.push_back(5'd0);
        pressed[0][0] = 1'b1;
        step(8 * FRAME);
        pressed[0][0] = 1'b0;
        step(8 * FRAME);
        checks++;
        if (n_xfer - x0 != 1) begin
            errors++; $display("FAIL rollover_count: got %0d transfers, expected 1", n_xfer - x0);
        end
    endtask

    task automatic test_overflow();
        int x0;
        evt_if.i_ready = 1'b0;
        x0 = n_xfer;
        for (int i = 0; i < 5; i++) begin
            func_pins[2] = 1'b1;
            step(6 * FRAME);
            func_pins[2] = 1'b0;
            step(6 * FRAME);
        end
        for (int i = 0; i < 4; i++) exp_q.push_back(5'd18);
        checks++;
        if (evt_if.o_valid !== 1'b1) begin
            errors++; $display("FAIL ovf_valid: got %b, expected 1", evt_if.o_valid);
        end
        checks++;
        if (evt_if.o_overflow !== 1'b1) begin
            errors++; $display("FAIL ovf_set: got %b, expected 1", evt_if.o_overflow);
        end
        checks++;
        if (evt_if.o_data !== 5'd18) begin
            errors++; $display("FAIL ovf_head: got %0d, expected 18", evt_if.o_data);
        end
        evt_if.i_ready = 1'b1;
        step(1);
        checks++;
        if (evt_if.o_overflow !== 1'b0) begin
            errors++; $display("FAIL ovf_clear: got %b, expected 0", evt_if.o_overflow);
        end
        step(10);
        checks++;
        if (n_xfer - x0 != 4) begin
            errors++; $display("FAIL ovf_drain_count: got %0d, expected 4", n_xfer - x0);
        end
        checks++;
        if (evt_if.o_valid !== 1'b0) begin
            errors++; $display("FAIL ovf_drained_valid: got %b, expected 0", evt_if.o_valid);
        end
        checks++;
        if (evt_if.o_data !== 5'd18) begin
            errors++; $display("FAIL ovf_hold_data: got %0d, expected 18", evt_if.o_data);
        end
    endtask

    task automatic test_reset_mid_frame();
        int x0;
        evt_if.i_ready = 1'b0;
        pressed[3][1] = 1'b1; step(6 * FRAME);
        pressed[3][1] = 1'b0; step(6 * FRAME);
        pressed[0][1] = 1'b1; step(6 * FRAME);
        pressed[0][1] = 1'b0; step(6 * FRAME);
        checks++;
        if (evt_if.o_valid !== 1'b1) begin
            errors++; $display("FAIL midrst_queued: got valid=%b, expected 1", evt_if.o_valid);
        end
        step(7);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (evt_if.o_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_valid: got %b, expected 0", evt_if.o_valid);
        end
        checks++;
        if (word_lines !== '0) begin
            errors++; $display("FAIL midrst_word_lines: got %b, expected 0000", word_lines);
        end
        checks++;
        if (evt_if.o_data !== '0) begin
            errors++; $display("FAIL midrst_data: got %0d, expected 0", evt_if.o_data);
        end
        step(2);
        @(negedge clk);
        rst_n = 1'b1;
        x0 = n_xfer;
        step(1);
        checks++;
        if (word_lines !== 4'b0001) begin
            errors++; $display("FAIL midrst_row0: got %b, expected 0001", word_lines);
        end
        evt_if.i_ready = 1'b1;
        step(2 * FRAME);
        checks++;
        if (n_xfer - x0 != 0) begin
            errors++; $display("FAIL midrst_lost: got %0d transfers, expected 0", n_xfer - x0);
        end
    endtask

`ifdef KEYPAD_AUTOREPEAT_EN
    task automatic test_autorepeat();
        int x0;
        int c0;
        evt_if.i_ready = 1'b1;
        x0 = n_xfer;
        c0 = xfer_cyc.size();
        for (int i = 0; i < 5; i++) exp_q.push_back(5'd5);
        pressed[1][1] = 1'b1;
        step(60 * FRAME);
        pressed[1][1] = 1'b0;
        step(8 * FRAME);
        checks++;
        if (n_xfer - x0 != 5) begin
            errors++; $display("FAIL repeat_count: got %0d, expected 5", n_xfer - x0);
        end else begin
            for (int i = 1; i < 5; i++) begin
                checks++;
                if (xfer_cyc[c0 + i] - xfer_cyc[c0 + i - 1] != ((i == 1) ? 32 * FRAME : 8 * FRAME))
                begin
                    errors++;
                    $display("FAIL repeat_gap%0d: got %0d cycles, expected %0d", i,
                             xfer_cyc[c0 + i] - xfer_cyc[c0 + i - 1],
                             (i == 1) ? 32 * FRAME : 8 * FRAME);
                end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_rollover();
        test_overflow();
        test_reset_mid_frame();
`ifdef KEYPAD_AUTOREPEAT_EN
        test_autorepeat();
`endif
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL final_pending: got %0d unmatched, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
